// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong paddle ADC sampler.
package pong_pkg;

   localparam int              ADC_W      = 16;
   localparam logic [ADC_W-1:0] ADC_POS_FS = 16'h7FFF;
   localparam logic [ADC_W-1:0] ADC_NEG_FS = 16'h8000;

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      ACCUM,
      SCALE,
      PUBLISH
   } state_e;

   function automatic logic is_full_scale(input logic [ADC_W-1:0] word);
      return (word == ADC_POS_FS) || (word == ADC_NEG_FS);
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, first at cycle DIV-1 after rst.
module sample_tick_gen #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == CW'(DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/adc_paddle_sampler.sv
// ADC-to-paddle sampler: glitch-filtered averaging, scaling, hysteresis, valid/ready output.
// Define PADDLE_INVERT_EN to flip the mapping so full-negative input gives SCREEN_MAX.
module adc_paddle_sampler
   import pong_pkg::*;
#(
   parameter int SAMPLE_DIV   = 50000,
   parameter int AVG_LOG2     = 3,
   parameter int POS_BITS     = 9,
   parameter int SCREEN_MAX   = 400,
   parameter int HYST         = 2,
   parameter int STABLE_TRIES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADC_W-1:0]    adc_data,
   input  logic                pos_ready,
   output logic [POS_BITS-1:0] paddle_pos,
   output logic                pos_valid,
   output logic                overrun,
   output logic                sat
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int TRY_W = $clog2(STABLE_TRIES + 1);

   logic tick;

   sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   state_e                    state_q, state_d;
   logic        [ADC_W-1:0]   s1_q, s2_q;
   logic signed [ADC_W-1:0]   sample_q, sample_d;
   logic        [TRY_W-1:0]   tries_q, tries_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic        [CNT_W-1:0]   cnt_q, cnt_d;
   logic        [POS_BITS-1:0] new_q, new_d;
   logic        [POS_BITS-1:0] paddle_pos_q, paddle_pos_d;
   logic                      pos_valid_q, pos_valid_d;
   logic                      overrun_q, overrun_d;
   logic                      sat_q, sat_d;

   logic signed [ACC_W-1:0]   shifted;
   logic        [ADC_W-1:0]   avg, off;
   logic        [31:0]        prod;
   logic        [POS_BITS-1:0] scaled, delta;
   logic                      stable;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d      = state_q;
      sample_d     = sample_q;
      tries_d      = tries_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      new_d        = new_q;
      paddle_pos_d = paddle_pos_q;
      pos_valid_d  = pos_valid_q && !pos_ready;
      overrun_d    = overrun_q;
      sat_d        = sat_q;

      stable  = (s1_q == s2_q);
      shifted = acc_q >>> AVG_LOG2;
      avg     = shifted[ADC_W-1:0];
      // Adding 32768 to a 16-bit signed value is just an MSB flip.
      off     = {~avg[ADC_W-1], avg[ADC_W-2:0]};
      prod    = 32'(off) * 32'(SCREEN_MAX);
`ifdef PADDLE_INVERT_EN
      scaled  = POS_BITS'(SCREEN_MAX) - POS_BITS'(prod >> 16);
`else
      scaled  = POS_BITS'(prod >> 16);
`endif
      delta   = (new_q > paddle_pos_q) ? new_q - paddle_pos_q : paddle_pos_q - new_q;

      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = CAPTURE;
               tries_d = TRY_W'(1);
            end
         end
         CAPTURE: begin
            // tries counts CAPTURE cycles, so a never-stable input leaves after STABLE_TRIES.
            if (stable || tries_q == TRY_W'(STABLE_TRIES)) begin
               sample_d = s2_q;
               state_d  = ACCUM;
            end else begin
               tries_d = tries_q + TRY_W'(1);
            end
         end
         ACCUM: begin
            acc_d = acc_q + ACC_W'(sample_q);
            cnt_d = cnt_q + CNT_W'(1);
            if (is_full_scale(sample_q)) sat_d = 1'b1;
            state_d = (cnt_q == CNT_W'((1 << AVG_LOG2) - 1)) ? SCALE : IDLE;
         end
         SCALE: begin
            new_d   = scaled;
            state_d = PUBLISH;
         end
         PUBLISH: begin
            if (delta > POS_BITS'(HYST)) begin
               paddle_pos_d = new_q;
               pos_valid_d  = 1'b1;
               if (pos_valid_q && !pos_ready) overrun_d = 1'b1;
            end
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         paddle_pos_q <= POS_BITS'(SCREEN_MAX / 2);
         pos_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         sat_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         paddle_pos_q <= paddle_pos_d;
         pos_valid_q  <= pos_valid_d;
         overrun_q    <= overrun_d;
         sat_q        <= sat_d;
      end
   end

   // NOTE: pure datapath registers are left unreset; each is written before the FSM reads it.
   always_ff @(posedge clk) begin
      s1_q     <= adc_data;
      s2_q     <= s1_q;
      sample_q <= sample_d;
      tries_q  <= tries_d;
      new_q    <= new_d;
   end

   assign paddle_pos = paddle_pos_q;
   assign pos_valid  = pos_valid_q;
   assign overrun    = overrun_q;
   assign sat        = sat_q;

endmodule

// File: tb/tb_adc_paddle_sampler.sv
// Directed self-checking bench for adc_paddle_sampler (SAMPLE_DIV=8, AVG_LOG2=2).
module tb_adc_paddle_sampler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] adc_data = 16'h0000;
   logic        pos_ready = 1'b0;
   logic [8:0]  paddle_pos;
   logic        pos_valid;
   logic        overrun;
   logic        sat;

   int n_checks = 0;
   int n_errors = 0;

`ifdef PADDLE_INVERT_EN
   localparam int P_4000 = 100;
   localparam int P_C000 = 300;
`else
   localparam int P_4000 = 300;
   localparam int P_C000 = 100;
`endif

   typedef struct {
      logic [15:0] adc;
      int          pos;
      logic        valid;
      logic        sat;
   } vec_t;

   vec_t vecs [9];

   always #5 clk = ~clk;

   adc_paddle_sampler #(
      .SAMPLE_DIV   (8),
      .AVG_LOG2     (2),
      .POS_BITS     (9),
      .SCREEN_MAX   (400),
      .HYST         (2),
      .STABLE_TRIES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .adc_data   (adc_data),
      .pos_ready  (pos_ready),
      .paddle_pos (paddle_pos),
      .pos_valid  (pos_valid),
      .overrun    (overrun),
      .sat        (sat)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Ends at the negedge just before the first post-reset posedge (E1).
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
`ifdef PADDLE_INVERT_EN
      vecs[0] = '{16'h0000, 200, 1'b0, 1'b0};
      vecs[1] = '{16'h4000, 100, 1'b1, 1'b0};
      vecs[2] = '{16'hC000, 300, 1'b1, 1'b0};
      vecs[3] = '{16'h8000, 400, 1'b1, 1'b1};
      vecs[4] = '{16'h7FFF,   1, 1'b1, 1'b1};
      vecs[5] = '{16'h0100, 200, 1'b0, 1'b0};
      vecs[6] = '{16'h0180, 200, 1'b0, 1'b0};
      vecs[7] = '{16'h0200, 197, 1'b1, 1'b0};
      vecs[8] = '{16'hFE00, 204, 1'b1, 1'b0};
`else
      vecs[0] = '{16'h0000, 200, 1'b0, 1'b0};
      vecs[1] = '{16'h4000, 300, 1'b1, 1'b0};
      vecs[2] = '{16'hC000, 100, 1'b1, 1'b0};
      vecs[3] = '{16'h8000,   0, 1'b1, 1'b1};
      vecs[4] = '{16'h7FFF, 399, 1'b1, 1'b1};
      vecs[5] = '{16'h0100, 200, 1'b0, 1'b0};
      vecs[6] = '{16'h0180, 200, 1'b0, 1'b0};
      vecs[7] = '{16'h0200, 203, 1'b1, 1'b0};
      vecs[8] = '{16'hFE00, 196, 1'b1, 1'b0};
`endif

      // Reset state.
      do_reset();
      check("reset_pos",     int'(paddle_pos), 200);
      check("reset_valid",   int'(pos_valid),  0);
      check("reset_overrun", int'(overrun),    0);
      check("reset_sat",     int'(sat),        0);

      // One full 4-sample window per vector; the update lands at E36.
      for (int i = 0; i < 9; i++) begin
         adc_data  = vecs[i].adc;
         pos_ready = 1'b0;
         do_reset();
         cycles(37);
         check($sformatf("vec%0d_pos", i),     int'(paddle_pos), vecs[i].pos);
         check($sformatf("vec%0d_valid", i),   int'(pos_valid),  int'(vecs[i].valid));
         check($sformatf("vec%0d_sat", i),     int'(sat),        int'(vecs[i].sat));
         check($sformatf("vec%0d_overrun", i), int'(overrun),    0);
      end

      // Stable-input latency: last tick sampled at E32, pos_valid visible after E36.
      adc_data = 16'h4000;
      do_reset();
      cycles(35);
      check("lat_valid_e35", int'(pos_valid), 0);
      cycles(1);
      check("lat_valid_e36", int'(pos_valid), 1);
      check("lat_pos_e36",   int'(paddle_pos), P_4000);

      // Back-pressure across two updates, then a one-cycle handshake.
      cycles(1);
      adc_data = 16'hC000;
      cycles(32);
      check("bp_pos",     int'(paddle_pos), P_C000);
      check("bp_valid",   int'(pos_valid),  1);
      check("bp_overrun", int'(overrun),    1);
      pos_ready = 1'b1;
      cycles(1);
      pos_ready = 1'b0;
      check("bp_hs_valid",   int'(pos_valid),  0);
      check("bp_hs_pos",     int'(paddle_pos), P_C000);
      check("bp_hs_overrun", int'(overrun),    1);

      // Update coinciding with a handshake keeps pos_valid high without overrun.
      adc_data = 16'h4000;
      do_reset();
      cycles(37);
      adc_data = 16'hC000;
      cycles(30);
      pos_ready = 1'b1;
      cycles(1);
      pos_ready = 1'b0;
      check("coin_valid",   int'(pos_valid),  1);
      check("coin_pos",     int'(paddle_pos), P_C000);
      check("coin_overrun", int'(overrun),    0);

      // Input toggling every clk: each CAPTURE lasts 4 cycles, so the update slips to E39.
      adc_data = 16'h4000;
      do_reset();
      repeat (38) begin
         @(posedge clk);
         @(negedge clk);
         adc_data = adc_data ^ 16'h0001;
      end
      check("glitch_valid_e38", int'(pos_valid), 0);
      @(posedge clk);
      @(negedge clk);
      check("glitch_valid_e39", int'(pos_valid),  1);
      check("glitch_pos",       int'(paddle_pos), P_4000);

      // Reset after two of four samples must leave no residue in the accumulator.
      adc_data = 16'h4000;
      do_reset();
      cycles(20);
      adc_data = 16'hC000;
      do_reset();
      cycles(37);
      check("midrst_pos",   int'(paddle_pos), P_C000);
      check("midrst_valid", int'(pos_valid),  1);
      check("midrst_sat",   int'(sat),        0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
